// File: rtl/fifo_sync_pkg.sv
// Shared types and helpers for the parametrised sync FIFO with delay-line mode.
package fifo_sync_pkg;

    localparam int unsigned FIFO_WIDTH = 8;

    typedef enum logic {
        MODE_FIFO = 1'b0,
        MODE_DLY  = 1'b1
    } fifo_mode_e;

    // Delay requests larger than the storage collapse to a full-depth delay.
    function automatic int unsigned clamp_dly(input int unsigned dly, input int unsigned depth);
        return (dly > depth) ? depth : dly;
    endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// DEPTH x WIDTH storage: one write port, one registered read port, no reset.
module fifo_sync_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read returns the pre-write word when both ports hit one address (full push+pop).
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fifo_sync_dly.sv
// Parametrised sync FIFO with occupancy, programmable almost flags and a delay-line mode.
// Optional sticky overflow/underflow flags are built when FIFO_SYNC_ERR_EN is defined.
module fifo_sync_dly
    import fifo_sync_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_dly,
    input  logic [AW:0]      dly_cfg,
    input  logic [AW:0]      af_thr,
    input  logic [AW:0]      ae_thr,
    input  logic             en,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_use,
    output logic [WIDTH-1:0] data_o,
    output logic             data_rd,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty
`ifdef FIFO_SYNC_ERR_EN
    ,
    input  logic             err_clr,
    output logic             ovf,
    output logic             udf
`endif
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    fifo_mode_e       mode;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      dly_lim;
    logic             pop;
    logic             push;
    logic             pass;
    logic             out_vld;
    logic             out_pass;
    logic [WIDTH-1:0] pass_q;
    logic [WIDTH-1:0] ram_q;

    assign mode    = fifo_mode_e'(mode_dly);
    assign dly_lim = (AW+1)'(clamp_dly(32'(dly_cfg), DEPTH));

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= af_thr);
    assign almost_empty = (count <= ae_thr);

    always_comb begin
        pop  = 1'b0;
        pass = 1'b0;
        if (mode == MODE_FIFO) begin
            pop = data_use && !empty;
        end else begin
            // Excess above the delay drains even without a write.
            pop  = !empty && ((en && (count >= dly_lim)) || (count > dly_lim));
            pass = en && empty && (dly_lim == '0);
        end
        push = en && (!full || pop) && !pass;
    end

    fifo_sync_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (data_i),
        .re    (pop),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_rd  <= 1'b0;
            out_vld  <= 1'b0;
            out_pass <= 1'b0;
            pass_q   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE;
            if (pop)  rd_ptr <= rd_ptr + ONE;
            count   <= count + (push ? ONE : '0) - (pop ? ONE : '0);
            data_rd <= pop || pass;
            if (pop || pass) begin
                out_vld  <= 1'b1;
                out_pass <= pass;
            end
            if (pass) pass_q <= data_i;
        end
    end

    // Output is zero until the first pop, then whichever source last produced a word.
    assign data_o = !out_vld ? '0 : (out_pass ? pass_q : ram_q);

    assert property (@(posedge clk) disable iff (!rst_n) count == (wr_ptr - rd_ptr));

`ifdef FIFO_SYNC_ERR_EN
    logic drop;
    assign drop = en && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (err_clr) begin
                ovf <= 1'b0;
                udf <= 1'b0;
            end
            if (drop) ovf <= 1'b1;
            if ((mode == MODE_FIFO) && data_use && empty) udf <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/fifo_sync_dly.md
Name: fifo_sync_dly

Overview:
- Parametrised successor of the 8-bit sync FIFO: generic width and depth, occupancy count, and programmable almost-full/almost-empty flags.
- Adds a delay-line mode: the FIFO acts as an N-sample delay, where N = dly_cfg, and pops automatically.
- Sits between a producer (en/data_i) and a consumer (data_use/data_o/data_rd) in the FIFO_delay datapath.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of entries; power of two, minimum 4.
- AW, $clog2(DEPTH), localparam address width; count and threshold ports are AW+1 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode_dly  in  1  0 = FIFO mode, 1 = delay-line mode.
- dly_cfg  in  AW+1  delay in samples for delay mode; values above DEPTH are clamped to DEPTH.
- af_thr  in  AW+1  almost-full threshold.
- ae_thr  in  AW+1  almost-empty threshold.
- en  in  1  write strobe.
- data_i  in  WIDTH  write data.
- data_use  in  1  read request; FIFO mode only.
- data_o  out  WIDTH  registered read data.
- data_rd  out  1  data_o valid, one-cycle pulse per pop.
- count  out  AW+1  occupancy, 0..DEPTH.
- full, empty, almost_full, almost_empty  out  1 each  status flags.

Behaviour:
- Reset (async, rst_n=0):
  - Pointers, count, data_o and data_rd all 0.
  - empty=1, almost_empty=1, full=0.
  - almost_full is the combinational result of count>=af_thr.
  - Storage array is not reset.
- Pointers: wr_ptr and rd_ptr are AW+1 bits; the MSB is a wrap bit; the low AW bits index storage and wrap DEPTH-1 -> 0.
- Flags, derived from registered count:
  - full = (count==DEPTH); empty = (count==0).
  - almost_full = (count>=af_thr); almost_empty = (count<=ae_thr).
- Push: en=1 and (!full or pop in the same cycle) writes data_i at wr_ptr. en=1 while full with no pop silently drops the word.
- FIFO-mode pop: data_use=1 and !empty.
  - data_o <= mem[rd_ptr] at the next edge; data_rd=1 for that one cycle (read latency 1).
  - data_use on empty is ignored: data_rd=0, data_o holds.
- Count update:
  - Simultaneous push and pop leave count unchanged.
  - Push and pop at full: both succeed.
  - Push and pop at empty: push only, data_rd=0.
- Delay-mode pop (data_use ignored; D = clamped dly_cfg):
  - en=1 and count>=D: pop together with the push, count steady at D. Output sample k equals input sample k-D.
  - count>D (e.g. after a mode switch or dly_cfg decrease): pop one word per cycle regardless of en until count==D. A push in such a cycle is still accepted.
  - D==0: pass-through. With en=1 and empty, data_o <= data_i and data_rd=1 next cycle; nothing is stored, count stays 0.
  - count<D: push only; the FIFO is filling.
- data_o holds its last popped value whenever data_rd=0.
- mode_dly and dly_cfg changes take effect on the next edge; contents are preserved.
- Reset mid-operation: contents are discarded immediately and all outputs take their reset values.

Optional Feature:
- Macro FIFO_SYNC_ERR_EN.
- Defined:
  - Adds input err_clr and sticky outputs ovf and udf, both reset to 0.
  - ovf sets on any dropped write.
  - udf sets on data_use while empty in FIFO mode.
  - err_clr=1 clears both; a set condition in the same cycle as err_clr wins.
- Undefined: these ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package fifo_sync_pkg:
  - FIFO_WIDTH default (8).
  - typedef enum logic {MODE_FIFO, MODE_DLY} fifo_mode_e.
  - Function clamp_dly(dly, depth).
- One sub-module, fifo_sync_ram: DEPTH x WIDTH, one write port and one synchronous read port, no reset.
- Pointers, count, flags and mode control live in fifo_sync_dly.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-traffic -> count=0, empty=1, almost_empty=1, full=0, data_rd=0, data_o=0 without waiting for a clock edge.
- Fill/drain (DEPTH=16, FIFO mode):
  - Write 0x00..0x0F -> full=1, count=16.
  - A 17th write of 0xAA is dropped (ovf=1 with ERR_EN).
  - 16 reads -> data_o 0x00..0x0F, each data_rd one cycle after its data_use, then empty=1.
  - A further read gives data_rd=0 (udf=1 with ERR_EN).
- Simultaneous at boundaries:
  - At full, en+data_use for 8 cycles -> count stays 16 and order is preserved.
  - At empty, en+data_use -> count=1, data_rd=0.
- Delay mode:
  - mode_dly=1, dly_cfg=3, en=1 continuously with data 1..10 -> data_rd first high the cycle after the 4th write, data_o=1,2,...,7, count holds 3.
  - Then dly_cfg=0 -> excess drains one per cycle, then pass-through: data_o equals the previous cycle's data_i.
- Thresholds: af_thr=12, ae_thr=2 -> almost_empty falls at count=3, almost_full rises at count=12, each tracking count in the same cycle.
